jt51_phrom_arb: RTL and testbench
=================================

Name: jt51_phrom_arb

Overview:
- Round-robin arbiter and sequencer that shares one registered phase/sine ROM (5-bit address, 46-bit word, 1-cycle read latency) among NREQ requesters, such as the operator phase stage, a debug readout and a test sequencer.
- Issues at most one ROM read per cycle.
- Tracks in-flight reads through a 2-stage pipeline.
- Returns each word to its requester with a done strobe and a requester ID.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 5, ROM address width
DW, 46, ROM data width
IDW, 2, requester ID width; must equal clog2(NREQ)

Ports:
clk  input  1  system clock, all logic on the rising edge
rst_n  input  1  synchronous reset, active low
req  input  NREQ  per-requester read request (level), held until done
addr  input  NREQ*AW  per-requester address; requester i uses bits [i*AW +: AW]; stable while req[i] is high
done  output  NREQ  one-cycle pulse to requester i when its word is on rd_data
rd_valid  output  1  OR of done
rd_id  output  IDW  requester index for the current rd_data
rd_data  output  DW  ROM word; equals rom_ph when rd_valid=1, else 0
rom_addr  output  AW  registered address to the ROM instance
rom_ph  input  DW  ROM registered data output
idle  output  1  high when no request is pending and the pipeline is empty

Behaviour:
- Reset (rst_n=0 at an edge):
  - rom_addr=0, s1_v=0, s2_v=0, done=0, rd_valid=0, rd_id=0.
  - Round-robin pointer ptr=NREQ-1, so requester 0 wins first.
  - Reset mid-operation flushes both stages. No done pulse is produced for flushed reads.
- Eligibility: elig[i] = req[i] & ~(s1_v & s1_id==i) & ~(s2_v & s2_id==i). A requester is never in flight twice.
- Arbitration (combinational, cycle T):
  - Scan elig starting at ptr+1, wrapping modulo NREQ. The first set bit gives g.
  - If no bit is set, no issue.
- Issue edge E1 (end of cycle T), when a grant exists:
  - rom_addr <= addr[g], s1_v <= 1, s1_id <= g, ptr <= g.
  - With no grant: s1_v <= 0; rom_addr and ptr hold.
- Edge E2:
  - The ROM registers the word for rom_addr.
  - s2_v <= s1_v, s2_id <= s1_id.
- Response cycle (after E2):
  - done[s2_id]=s2_v, rd_valid=s2_v, rd_id=s2_id (0 when invalid).
  - rd_data = rom_ph gated by s2_v.
- Latency:
  - A req first sampled at E1 with no contention produces done in the cycle after E2, i.e. 2 clocks.
  - Aggregate throughput is 1 read/clk.
  - Per-requester throughput is 1 read per 3 clk, because the requester is masked while in s1 and s2.
- Handshake:
  - The requester drops req (or changes addr for a new read) on the edge that samples done.
  - The mask on s2 guarantees no double issue at that edge.
  - req held high afterwards is a new request.
- Abort: if req[i] falls while i is in flight, the read still completes and done[i] still pulses. The requester ignores it.
- Fairness: with all NREQ requesting continuously, grants rotate 0,1,..,NREQ-1,0, and each waits at most NREQ-1 cycles.
- idle = ~|req & ~s1_v & ~s2_v.

Optional Feature:
JT51_PHROM_ARB_PRIO_EN:
- Defined:
  - Requester 0 has strict priority: if elig[0]=1 it wins regardless of ptr, and ptr is not updated.
  - Others arbitrate round-robin as above.
  - Requester 0 (the operator pipeline) then sees fixed 2-clk latency whenever it is eligible.
- Undefined: pure round-robin for all requesters.

Test Plan:
- Bench ROM model: 1-clk registered, word = {41'd0, addr}. Reset: hold rst_n=0 for 3 clk with req=4'b1111 -> done=0, rd_valid=0, rom_addr=0, idle=0; after release, the first grant goes to requester 0.
- Single request: req[2]=1, addr[2]=5'd17 at cycle 0 -> rom_addr=17 after E1; done=4'b0100, rd_id=2, rd_data=46'd17 in cycle 2; idle=1 in cycle 3 after req drops.
- Full contention: all 4 requesters hold req with addrs 3,7,11,31 and re-request after done -> grant order 0,1,2,3,0,...; rd_valid=1 every cycle from cycle 2; each done is separated by exactly 4 cycles.
- Abort and reset: requester 1 drops req after issue -> done[1] still pulses with the correct data. Asserting rst_n=0 while s1_v=s2_v=1 -> no done pulse; the pipeline is empty on release.
- Hold-after-done: requester 3 keeps req high continuously, alone, addr=9 -> done[3] pulses every 3rd cycle (cycles 2,5,8) with no duplicate.
- With JT51_PHROM_ARB_PRIO_EN and all req high -> requester 0 is served every 3 cycles; others share the gaps round-robin 1,2,3. Without the macro, the order is 0,1,2,3.

Source files
------------

// File: rtl/jt51_phrom_arb.sv
// jt51_phrom_arb
// Round-robin arbiter that shares one registered phase/sine ROM among NREQ
// requesters. It issues at most one read per clock and tracks each read
// through a two-stage pipeline:
//   - s1: the address is being presented to the ROM.
//   - s2: the ROM word is valid on rom_ph_i.
// Each word is returned with a one-cycle done strobe and a requester ID.
//
// Ports
//   clk_i       system clock, rising edge
//   rst_n_i     synchronous reset, active low
//   req_i       per-requester read request (level), held until done
//   addr_i      per-requester address, requester i at [i*AW +: AW]
//   done_o      one-cycle pulse to the requester whose word is on rd_data_o
//   rd_valid_o  OR of done_o
//   rd_id_o     requester index for rd_data_o (0 when invalid)
//   rd_data_o   ROM word while rd_valid_o is high, else 0
//   rom_addr_o  registered address driven to the ROM
//   rom_ph_i    registered ROM data (1-clock read latency)
//   idle_o      no request pending and pipeline empty
//
// Parameters: NREQ (2..8), AW, DW, IDW (must equal clog2(NREQ)).
//
// Optional macro JT51_PHROM_ARB_PRIO_EN:
//   Requester 0 gets strict priority whenever it is eligible, and that grant
//   leaves the round-robin pointer untouched. The remaining requesters
//   rotate as usual. Without the macro, all requesters are round-robin.

module jt51_phrom_arb #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 46,
  parameter int IDW  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*AW-1:0]   addr_i,
  output logic [NREQ-1:0]      done_o,
  output logic                 rd_valid_o,
  output logic [IDW-1:0]       rd_id_o,
  output logic [DW-1:0]        rd_data_o,
  output logic [AW-1:0]        rom_addr_o,
  input  logic [DW-1:0]        rom_ph_i,
  output logic                 idle_o
);

  logic [AW-1:0]   rom_addr_q, rom_addr_d;
  logic            s1_v_q, s1_v_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;
  logic            s2_v_q, s2_v_d;
  logic [IDW-1:0]  s2_id_q, s2_id_d;
  logic [IDW-1:0]  ptr_q, ptr_d;

  logic [NREQ-1:0] elig;
  logic            grant_v;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  scan_id;
  logic            rr_update;

  // A requester still in s1 or s2 is masked, so it can never be in flight
  // twice. The s2 mask also covers the edge on which done is sampled.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_i[i]
              & ~(s1_v_q & (s1_id_q == IDW'(i)))
              & ~(s2_v_q & (s2_id_q == IDW'(i)));
    end
  end

  // Scan starts one past the last round-robin winner and wraps modulo NREQ.
  always_comb begin
    grant_v   = 1'b0;
    grant_id  = '0;
    scan_id   = '0;
    rr_update = 1'b0;
`ifdef JT51_PHROM_ARB_PRIO_EN
    if (elig[0]) begin
      grant_v = 1'b1;
    end
`endif
    for (int k = 1; k <= NREQ; k++) begin
      scan_id = IDW'((int'(ptr_q) + k) % NREQ);
      if (!grant_v && elig[scan_id]) begin
        grant_v   = 1'b1;
        grant_id  = scan_id;
        rr_update = 1'b1;
      end
    end
  end

  always_comb begin
    rom_addr_d = grant_v ? addr_i[grant_id*AW +: AW] : rom_addr_q;
    s1_v_d     = grant_v;
    s1_id_d    = grant_v ? grant_id : s1_id_q;
    ptr_d      = rr_update ? grant_id : ptr_q;
    s2_v_d     = s1_v_q;
    s2_id_d    = s1_id_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rom_addr_q <= '0;
      s1_v_q     <= 1'b0;
      s1_id_q    <= '0;
      s2_v_q     <= 1'b0;
      s2_id_q    <= '0;
      ptr_q      <= IDW'(NREQ - 1);
    end else begin
      rom_addr_q <= rom_addr_d;
      s1_v_q     <= s1_v_d;
      s1_id_q    <= s1_id_d;
      s2_v_q     <= s2_v_d;
      s2_id_q    <= s2_id_d;
      ptr_q      <= ptr_d;
    end
  end

  always_comb begin
    done_o = '0;
    if (s2_v_q) begin
      done_o[s2_id_q] = 1'b1;
    end
  end

  assign rd_valid_o = s2_v_q;
  assign rd_id_o    = s2_v_q ? s2_id_q : '0;
  assign rd_data_o  = s2_v_q ? rom_ph_i : '0;
  assign rom_addr_o = rom_addr_q;
  assign idle_o     = ~|req_i & ~s1_v_q & ~s2_v_q;

endmodule

// File: tb/tb_jt51_phrom_arb.sv
module tb_jt51_phrom_arb;

  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 46;
  localparam int IDW  = 2;
  localparam int NCYC = 400;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req;
  logic [NREQ*AW-1:0]  addr;
  logic [NREQ-1:0]     done;
  logic                rd_valid;
  logic [IDW-1:0]      rd_id;
  logic [DW-1:0]       rd_data;
  logic [AW-1:0]       rom_addr;
  logic [DW-1:0]       rom_ph;
  logic                idle;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_ph <= {41'd0, rom_addr};

  jt51_phrom_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .IDW(IDW)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .req_i      (req),
    .addr_i     (addr),
    .done_o     (done),
    .rd_valid_o (rd_valid),
    .rd_id_o    (rd_id),
    .rd_data_o  (rd_data),
    .rom_addr_o (rom_addr),
    .rom_ph_i   (rom_ph),
    .idle_o     (idle)
  );

  typedef struct {
    logic [3:0]  req;
    logic [19:0] addr;
    logic [3:0]  done;
    logic [1:0]  id;
    logic [45:0] data;
    logic [4:0]  rom;
    logic        idle;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] r, input logic [19:0] a, input logic [3:0] d,
                     input logic [1:0] i, input logic [45:0] dt, input logic [4:0] ro,
                     input logic id_l);
    vec_t v;
    v.req = r; v.addr = a; v.done = d; v.id = i; v.data = dt; v.rom = ro; v.idle = id_l;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [19:0] A_S  = {5'd0, 5'd17, 5'd0, 5'd0};
  localparam logic [19:0] A_AB = {5'd0, 5'd0, 5'd22, 5'd0};
  localparam logic [19:0] A_H  = {5'd9, 15'd0};
  localparam logic [19:0] A_C  = {5'd31, 5'd11, 5'd7, 5'd3};

  // random-phase reference: per-cycle grant history
  bit          gv [0:NCYC-1];
  int          gid[0:NCYC-1];
  logic [4:0]  ga [0:NCYC-1];

  initial begin
    int          last;
    logic [4:0]  mrom;
    logic [3:0]  rq, busy, elig, e_done;
    logic [19:0] ad;
    logic [1:0]  e_id;
    logic [45:0] e_data;
    logic        e_idle;

    // ---- reset with all requests high
    rst_n = 1'b0; req = 4'hF; addr = A_C;
    repeat (3) begin
      step();
      @(negedge clk);
      check("rst done", 64'(done), 0);
      check("rst rd_valid", 64'(rd_valid), 0);
      check("rst rom_addr", 64'(rom_addr), 0);
      check("rst idle", 64'(idle), 0);
    end
    step();
    rst_n = 1'b1;
    @(negedge clk); check("post-rst c0 done", 64'(done), 0);
    step();
    @(negedge clk); check("post-rst c1 rom_addr", 64'(rom_addr), 3);
    step();
    @(negedge clk);
    check("post-rst first done", 64'(done), 64'h1);
    check("post-rst first id", 64'(rd_id), 0);

    // ---- table-driven sequence from a fresh reset
    rst_n = 1'b0; req = '0; addr = '0;
    step(); step();
    rst_n = 1'b1;

    add(4'b0100, A_S, 4'b0000, 2'd0, 46'd0,  5'd0,  1'b0);
    add(4'b0100, A_S, 4'b0000, 2'd0, 46'd0,  5'd17, 1'b0);
    add(4'b0100, A_S, 4'b0100, 2'd2, 46'd17, 5'd17, 1'b0);
    add(4'b0000, A_S, 4'b0000, 2'd0, 46'd0,  5'd17, 1'b1);
    add(4'b0010, A_AB, 4'b0000, 2'd0, 46'd0,  5'd17, 1'b0);
    add(4'b0000, A_AB, 4'b0000, 2'd0, 46'd0,  5'd22, 1'b0);
    add(4'b0000, A_AB, 4'b0010, 2'd1, 46'd22, 5'd22, 1'b0);
    add(4'b0000, A_AB, 4'b0000, 2'd0, 46'd0,  5'd22, 1'b1);
    add(4'b1000, A_H, 4'b0000, 2'd0, 46'd0, 5'd22, 1'b0);
    add(4'b1000, A_H, 4'b0000, 2'd0, 46'd0, 5'd9,  1'b0);
    add(4'b1000, A_H, 4'b1000, 2'd3, 46'd9, 5'd9,  1'b0);
    add(4'b1000, A_H, 4'b0000, 2'd0, 46'd0, 5'd9,  1'b0);
    add(4'b1000, A_H, 4'b0000, 2'd0, 46'd0, 5'd9,  1'b0);
    add(4'b1000, A_H, 4'b1000, 2'd3, 46'd9, 5'd9,  1'b0);
    add(4'b1000, A_H, 4'b0000, 2'd0, 46'd0, 5'd9,  1'b0);
    add(4'b1000, A_H, 4'b0000, 2'd0, 46'd0, 5'd9,  1'b0);
    add(4'b1000, A_H, 4'b1000, 2'd3, 46'd9, 5'd9,  1'b0);
    add(4'b0000, A_H, 4'b0000, 2'd0, 46'd0, 5'd9,  1'b1);
    add(4'b1111, A_C, 4'b0000, 2'd0, 46'd0,  5'd9,  1'b0);
    add(4'b1111, A_C, 4'b0000, 2'd0, 46'd0,  5'd3,  1'b0);
`ifdef JT51_PHROM_ARB_PRIO_EN
    add(4'b1111, A_C, 4'b0001, 2'd0, 46'd3,  5'd7,  1'b0);
    add(4'b1111, A_C, 4'b0010, 2'd1, 46'd7,  5'd11, 1'b0);
    add(4'b1111, A_C, 4'b0100, 2'd2, 46'd11, 5'd3,  1'b0);
    add(4'b1111, A_C, 4'b0001, 2'd0, 46'd3,  5'd31, 1'b0);
    add(4'b1111, A_C, 4'b1000, 2'd3, 46'd31, 5'd7,  1'b0);
    add(4'b1111, A_C, 4'b0010, 2'd1, 46'd7,  5'd3,  1'b0);
`else
    add(4'b1111, A_C, 4'b0001, 2'd0, 46'd3,  5'd7,  1'b0);
    add(4'b1111, A_C, 4'b0010, 2'd1, 46'd7,  5'd11, 1'b0);
    add(4'b1111, A_C, 4'b0100, 2'd2, 46'd11, 5'd31, 1'b0);
    add(4'b1111, A_C, 4'b1000, 2'd3, 46'd31, 5'd3,  1'b0);
    add(4'b1111, A_C, 4'b0001, 2'd0, 46'd3,  5'd7,  1'b0);
    add(4'b1111, A_C, 4'b0010, 2'd1, 46'd7,  5'd11, 1'b0);
`endif

    foreach (tbl[k]) begin
      req = tbl[k].req; addr = tbl[k].addr;
      @(negedge clk);
      check($sformatf("row%0d done", k),     64'(done),     64'(tbl[k].done));
      check($sformatf("row%0d rd_valid", k), 64'(rd_valid), 64'(|tbl[k].done));
      check($sformatf("row%0d rd_id", k),    64'(rd_id),    64'(tbl[k].id));
      check($sformatf("row%0d rd_data", k),  64'(rd_data),  64'(tbl[k].data));
      check($sformatf("row%0d rom_addr", k), 64'(rom_addr), 64'(tbl[k].rom));
      check($sformatf("row%0d idle", k),     64'(idle),     64'(tbl[k].idle));
      step();
    end

    // ---- reset while both stages are full: no done for flushed reads
    rst_n = 1'b0; req = '0;
    @(negedge clk);
    check("pre-flush rd_valid", 64'(rd_valid), 1);
    step();
    @(negedge clk);
    check("flush done", 64'(done), 0);
    check("flush idle", 64'(idle), 1);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("after-flush%0d done", k), 64'(done), 0);
      check($sformatf("after-flush%0d idle", k), 64'(idle), 1);
      step();
    end

    // ---- randomized traffic against a cycle-history reference
    rst_n = 1'b0; req = '0;
    step(); step();
    rst_n = 1'b1;
    last = NREQ - 1;
    mrom = '0;
    for (int c = 0; c < NCYC; c++) begin
      rq = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      ad = 20'($urandom);
      req = rq; addr = ad;
      @(negedge clk);
      e_done = '0; e_id = '0; e_data = '0; busy = '0;
      if (c >= 2 && gv[c-2]) begin
        e_done = 4'(1 << gid[c-2]);
        e_id   = 2'(gid[c-2]);
        e_data = {41'd0, ga[c-2]};
        busy[gid[c-2]] = 1'b1;
      end
      if (c >= 1 && gv[c-1]) busy[gid[c-1]] = 1'b1;
      e_idle = (rq == 0) && !(c >= 1 && gv[c-1]) && !(c >= 2 && gv[c-2]);
      check($sformatf("rnd%0d done", c),     64'(done),     64'(e_done));
      check($sformatf("rnd%0d rd_valid", c), 64'(rd_valid), 64'(|e_done));
      check($sformatf("rnd%0d rd_id", c),    64'(rd_id),    64'(e_id));
      check($sformatf("rnd%0d rd_data", c),  64'(rd_data),  64'(e_data));
      check($sformatf("rnd%0d rom_addr", c), 64'(rom_addr), 64'(mrom));
      check($sformatf("rnd%0d idle", c),     64'(idle),     64'(e_idle));
      elig = rq & ~busy;
      gv[c] = 1'b0; gid[c] = 0; ga[c] = '0;
`ifdef JT51_PHROM_ARB_PRIO_EN
      if (elig[0]) begin gv[c] = 1'b1; gid[c] = 0; end
`endif
      for (int k = 1; k <= NREQ; k++) begin
        int j;
        j = (last + k) % NREQ;
        if (!gv[c] && elig[j]) begin
          gv[c] = 1'b1; gid[c] = j; last = j;
        end
      end
      if (gv[c]) ga[c] = ad[gid[c]*AW +: AW];
      step();
      if (gv[c]) mrom = ga[c];
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
